time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Front-panel controller that sequences the time-of-day counter through its set mode. Turns synchronized MODE/UP/DOWN button levels into a field-select FSM (RUN → HR → MN → SC → RUN), single-cycle inc/dec commands with hold-to-auto-repeat, and an idle timeout back to RUN. The time counter consumes `run_en`, `sel`, `inc` and `dec` and owns no button logic of its own.

## Interface
- `HOLD_CYCLES`, default 512: cycles from the first pulse to the first auto-repeat pulse; ≥ 2.
- `REPEAT_CYCLES`, default 64: cycles between later auto-repeat pulses; 1 ≤ REPEAT_CYCLES ≤ HOLD_CYCLES.
- `TIMEOUT_CYCLES`, default 4096: idle cycles in a SET state before returning to RUN; ≥ 2.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode_btn`  in  1  MODE button level, already synchronized and debounced, active-high.
- `up_btn`  in  1  UP button level, same conditioning.
- `down_btn`  in  1  DOWN button level, same conditioning.
- `run_en`  out  1  1 = time counter free-runs; 0 = counter frozen for setting.
- `sel`  out  3  one-hot field select: 3'b100 HR, 3'b010 MN, 3'b001 SC, 3'b000 in RUN.
- `inc`  out  1  one-cycle pulse: increment the selected field.
- `dec`  out  1  one-cycle pulse: decrement the selected field.

## Operation
- States: RUN, SET_HR, SET_MN, SET_SC. Reset enters RUN.
- A MODE rising edge advances the state: RUN→SET_HR→SET_MN→SET_SC→RUN.
- Outputs in RUN: `run_en`=1, `sel`=0.
- Outputs in SET_x: `run_en`=0, `sel` = one-hot of field x.
- UP and DOWN are ignored in RUN. Their edge detectors still track levels, so a button held on entry to SET does not fire until it is released and pressed again.
- Press pulse: a rising edge on UP in a SET state gives one `inc` pulse; DOWN gives `dec` in the same way.
- Auto-repeat: while the button stays high, a second pulse follows HOLD_CYCLES after the first. Further pulses follow every REPEAT_CYCLES until release.
- Release clears the hold counter.
- UP and DOWN high together: no pulses, and both hold counters cleared. A pulse is never issued from a simultaneous edge. `inc` and `dec` are never high together.
- A MODE edge in the same cycle as an UP/DOWN event: MODE wins, the pulse is suppressed and both hold counters are cleared.
- Timeout: an idle counter runs only in SET states. It clears on any MODE/UP/DOWN rising edge and on any repeat pulse.
- When the idle counter reaches TIMEOUT_CYCLES-1, the next state is RUN.
- Counter widths: $clog2 of the respective parameter plus 1. The counters never wrap; they are reloaded or cleared.
- The field arithmetic (59/23 wrap) belongs to the time counter, not to this block.

## Timing
- Reset values (asynchronous, immediate): state RUN, `run_en`=1, `sel`=0, `inc`=0, `dec`=0, all counters and edge registers 0.
- All outputs are registered.
- Edge at cycle N, meaning the button is sampled 1 at N and was 0 at N-1: pulse high in cycle N+1 for exactly one cycle.
- MODE edge sampled at N: new `sel`/`run_en` visible in cycle N+1.
- Repeat pulses, with the first pulse at cycle P: P+HOLD_CYCLES, then +REPEAT_CYCLES each.
- Timeout, with the last activity at cycle A and no further activity: `run_en`=1 and `sel`=0 from cycle A+TIMEOUT_CYCLES+1.
- Deassertion of `rst_n` mid-hold: no pulse until a fresh rising edge.

## Structure
- Shared package `time_set_pkg`:
  - `ts_state_e` enum (RUN, SET_HR, SET_MN, SET_SC).
  - Select constants SEL_HR=3'b100, SEL_MN=3'b010, SEL_SC=3'b001, SEL_NONE=3'b000.
  - The time counter imports the same select constants.
- Sub-module `btn_repeat`, instantiated twice (UP, DOWN).
  - Contains the edge register, the hold/repeat counter and the raw pulse output.
  - Takes `enable` and `clear` inputs; parameterized by HOLD_CYCLES and REPEAT_CYCLES.
- Top level contains the FSM, the idle counter, UP/DOWN conflict and MODE-priority masking, and the output registers.

## Test plan
Bench parameters: HOLD_CYCLES=8, REPEAT_CYCLES=4, TIMEOUT_CYCLES=32.
- Reset, then 3 MODE presses, then a 4th → `sel` 100, 010, 001, 000. `run_en` is 0 during the first three states and 1 after the 4th.
- SET_MN, UP pressed at cycle 10 and held to cycle 30 → `inc` pulses at cycles 11, 19, 23, 27 only, and `dec` stays 0.
- SET_HR, UP and DOWN rise together and are held 20 cycles → no `inc` or `dec` pulse. Releasing DOWN alone gives no pulse until UP is re-pressed.
- SET_SC, last UP pulse at cycle 50, no further input → `run_en`=1 and `sel`=0 at cycle 51+32.
- UP held from RUN into SET_HR → no pulses. Release then re-press → exactly one `inc` one cycle after the edge.
- `rst_n` low for 1 cycle while in SET_MN with UP held → immediately `sel`=0, `run_en`=1, `inc`=0. After release, pulses appear only after a new MODE press and a new UP edge.

Source files
------------

// File: rtl/time_set_pkg.sv
// Shared definitions for the time-of-day set controller and the time counter.
// The select constants are the contract between the two blocks.
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HR = 2'd1,
    SET_MN = 2'd2,
    SET_SC = 2'd3
  } ts_state_e;

  localparam logic [2:0] SEL_HR   = 3'b100;
  localparam logic [2:0] SEL_MN   = 3'b010;
  localparam logic [2:0] SEL_SC   = 3'b001;
  localparam logic [2:0] SEL_NONE = 3'b000;

  function automatic logic [2:0] sel_of(input ts_state_e s);
    case (s)
      SET_HR:  return SEL_HR;
      SET_MN:  return SEL_MN;
      SET_SC:  return SEL_SC;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_repeat.sv
// Button edge detector with hold-to-auto-repeat.
// The edge register always tracks the level, so a button already held when enabled never fires.
module btn_repeat #(
  parameter int HOLD_CYCLES   = 512,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic enable,
  input  logic clear,
  output logic rise,
  output logic pulse
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;

  logic          prev;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          press;
  logic          rpt;

  assign rise  = btn & ~prev;
  assign press = rise & enable;
  // Only a hold that began with a real press in an enabled state may repeat.
  assign rpt   = armed & btn & enable & (cnt == '0);
  assign pulse = press | rpt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      prev <= btn;
      if (clear || !enable || !btn) begin
        armed <= 1'b0;
        cnt   <= '0;
      end else if (press) begin
        armed <= 1'b1;
        cnt   <= CW'(HOLD_CYCLES - 1);
      end else if (rpt) begin
        cnt <= CW'(REPEAT_CYCLES - 1);
      end else if (armed) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel set-mode sequencer: MODE walks RUN->HR->MN->SC->RUN, UP/DOWN give
// inc/dec pulses with auto-repeat, and an idle timeout drops back to RUN.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int HOLD_CYCLES    = 512,
  parameter int REPEAT_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  output logic       run_en,
  output logic [2:0] sel,
  output logic       inc,
  output logic       dec
);

  localparam int IW = $clog2(TIMEOUT_CYCLES) + 1;

  ts_state_e     state;
  ts_state_e     next_state;
  logic          mode_prev;
  logic          mode_rise;
  logic          set_mode;
  logic          clear;
  logic          up_rise;
  logic          up_pulse;
  logic          down_rise;
  logic          down_pulse;
  logic          act;
  logic          act_p1;
  logic          timeout;
  logic [IW-1:0] idle;

  assign set_mode  = (state != RUN);
  assign mode_rise = mode_btn & ~mode_prev;
  // MODE edges and UP+DOWN together both kill pending pulses and hold timers.
  assign clear     = mode_rise | (up_btn & down_btn);
  assign act       = mode_rise | up_rise | down_rise | up_pulse | down_pulse;

  btn_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (up_btn),
    .enable(set_mode),
    .clear (clear),
    .rise  (up_rise),
    .pulse (up_pulse)
  );

  btn_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (down_btn),
    .enable(set_mode),
    .clear (clear),
    .rise  (down_rise),
    .pulse (down_pulse)
  );

  // Idle time is measured from the cycle the activity becomes visible, hence
  // the registered activity flag; a timeout never races an activity event.
  assign timeout = set_mode && (idle == IW'(TIMEOUT_CYCLES - 1)) && !act && !act_p1;

  always_comb begin
    next_state = state;
    if (mode_rise) begin
      case (state)
        RUN:     next_state = SET_HR;
        SET_HR:  next_state = SET_MN;
        SET_MN:  next_state = SET_SC;
        default: next_state = RUN;
      endcase
    end else if (timeout) begin
      next_state = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      mode_prev <= 1'b0;
      act_p1    <= 1'b0;
      idle      <= '0;
      run_en    <= 1'b1;
      sel       <= SEL_NONE;
      inc       <= 1'b0;
      dec       <= 1'b0;
    end else begin
      state     <= next_state;
      mode_prev <= mode_btn;
      act_p1    <= act;
      if (!set_mode || act_p1) idle <= '0;
      else                     idle <= idle + 1'b1;
      run_en    <= (next_state == RUN);
      sel       <= sel_of(next_state);
      inc       <= up_pulse & ~clear;
      dec       <= down_pulse & ~clear;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: a vector table for field sequencing and
// button masking, plus hand-written repeat, timeout and reset sequences.
module tb_time_set_ctrl;

  logic       clk;
  logic       rst_n;
  logic       mode_btn;
  logic       up_btn;
  logic       down_btn;
  logic       run_en;
  logic [2:0] sel;
  logic       inc;
  logic       dec;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic       mode;
    logic       up;
    logic       down;
    logic       run_en;
    logic [2:0] sel;
    logic       inc;
    logic       dec;
  } vec_t;

  vec_t tbl [0:22];
  int   ntbl = 0;

  time_set_ctrl #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode_btn(mode_btn),
    .up_btn  (up_btn),
    .down_btn(down_btn),
    .run_en  (run_en),
    .sel     (sel),
    .inc     (inc),
    .dec     (dec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nvec++;
    if (actual !== expected) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic r, input logic [2:0] s,
                         input logic i, input logic d);
    chk({name, ".run_en"}, 8'(run_en), 8'(r));
    chk({name, ".sel"},    8'(sel),    8'(s));
    chk({name, ".inc"},    8'(inc),    8'(i));
    chk({name, ".dec"},    8'(dec),    8'(d));
  endtask

  task automatic add(input logic m, input logic u, input logic d, input logic r,
                     input logic [2:0] s, input logic i, input logic dc);
    tbl[ntbl] = '{mode: m, up: u, down: d, run_en: r, sel: s, inc: i, dec: dc};
    ntbl++;
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    step();
  endtask

  initial begin
    rst_n    = 1'b1;
    mode_btn = 1'b0;
    up_btn   = 1'b0;
    down_btn = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all("reset", 1'b1, 3'b000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // mode up dn | run sel inc dec
    add(0, 0, 0, 1, 3'b000, 0, 0);  // idle RUN
    add(1, 0, 0, 0, 3'b100, 0, 0);  // -> HR
    add(0, 0, 0, 0, 3'b100, 0, 0);
    add(1, 0, 0, 0, 3'b010, 0, 0);  // -> MN
    add(0, 0, 0, 0, 3'b010, 0, 0);
    add(1, 0, 0, 0, 3'b001, 0, 0);  // -> SC
    add(0, 0, 0, 0, 3'b001, 0, 0);
    add(1, 0, 0, 1, 3'b000, 0, 0);  // -> RUN
    add(0, 0, 0, 1, 3'b000, 0, 0);
    add(0, 1, 0, 1, 3'b000, 0, 0);  // UP edge ignored in RUN
    add(1, 1, 0, 0, 3'b100, 0, 0);  // held UP carried into HR
    add(0, 1, 0, 0, 3'b100, 0, 0);
    add(0, 1, 0, 0, 3'b100, 0, 0);
    add(0, 0, 0, 0, 3'b100, 0, 0);
    add(0, 1, 0, 0, 3'b100, 1, 0);  // fresh edge -> inc
    add(0, 0, 0, 0, 3'b100, 0, 0);
    add(1, 1, 0, 0, 3'b010, 0, 0);  // MODE beats UP edge
    add(0, 1, 0, 0, 3'b010, 0, 0);
    add(0, 0, 0, 0, 3'b010, 0, 0);
    add(0, 0, 1, 0, 3'b010, 0, 1);  // DOWN edge -> dec
    add(0, 0, 0, 0, 3'b010, 0, 0);
    add(0, 1, 1, 0, 3'b010, 0, 0);  // simultaneous edges
    add(0, 0, 0, 0, 3'b010, 0, 0);

    for (int k = 0; k < ntbl; k++) begin
      mode_btn = tbl[k].mode;
      up_btn   = tbl[k].up;
      down_btn = tbl[k].down;
      step();
      chk_all($sformatf("vec%0d", k), tbl[k].run_en, tbl[k].sel, tbl[k].inc, tbl[k].dec);
    end

    // SET_MN -> SET_SC -> RUN -> SET_HR, then UP+DOWN held together
    press_mode();
    press_mode();
    press_mode();
    chk("conf.sel_hr", 8'(sel), 8'h4);
    up_btn   = 1'b1;
    down_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("conf.both%0d", k), {6'd0, inc, dec}, 8'h0);
    end
    down_btn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("conf.uponly%0d", k), {6'd0, inc, dec}, 8'h0);
    end
    up_btn = 1'b0;
    step();
    up_btn = 1'b1;
    step();
    chk_all("conf.repress", 1'b0, 3'b100, 1'b1, 1'b0);
    up_btn = 1'b0;
    step();

    // SET_MN: UP held for 20 sampled cycles; pulses at offsets 0, 8, 12, 16
    press_mode();
    chk("rep.sel_mn", 8'(sel), 8'h2);
    up_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("rep.inc%0d", k), 8'(inc),
          8'((k == 0) || (k == 8) || (k == 12) || (k == 16)));
      chk($sformatf("rep.dec%0d", k), 8'(dec), 8'h0);
    end
    up_btn = 1'b0;
    step();
    chk("rep.inc_release", 8'(inc), 8'h0);

    // SET_SC: one UP pulse, then idle until timeout 33 cycles after the pulse
    press_mode();
    chk("tmo.sel_sc", 8'(sel), 8'h1);
    up_btn = 1'b1;
    step();
    chk("tmo.pulse", 8'(inc), 8'h1);
    up_btn = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      step();
      if (k == 32) chk_all("tmo.before", 1'b0, 3'b001, 1'b0, 1'b0);
      if (k == 33) chk_all("tmo.after",  1'b1, 3'b000, 1'b0, 1'b0);
    end

    // Reset mid-hold in SET_MN
    press_mode();
    press_mode();
    up_btn = 1'b1;
    step();
    chk_all("rst.pre_pulse", 1'b0, 3'b010, 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    #1 chk_all("rst.async", 1'b1, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("rst.run%0d", k), 1'b1, 3'b000, 1'b0, 1'b0);
    end
    mode_btn = 1'b1;
    step();
    chk_all("rst.mode", 1'b0, 3'b100, 1'b0, 1'b0);
    mode_btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("rst.held%0d", k), 8'(inc), 8'h0);
    end
    up_btn = 1'b0;
    step();
    up_btn = 1'b1;
    step();
    chk_all("rst.fresh", 1'b0, 3'b100, 1'b1, 1'b0);
    up_btn = 1'b0;
    step();
    chk("rst.single", 8'(inc), 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
